// File: rtl/uart_tx_param_if.sv
// Transmit-side bus for uart_tx_param: write strobe/payload in, line and status out.
// master = the producer that writes bytes, slave = the transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Tx_DV;
  logic [DATA_BITS-1:0] i_Tx_Byte;
  logic                 o_Tx_Ready;
  logic                 o_Tx_Serial;
  logic                 o_Tx_Active;
  logic                 o_Tx_Done;
  logic [6:0]           o_Tx_Level;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Serial,
    input  o_Tx_Active,
    input  o_Tx_Done,
    input  o_Tx_Level
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Serial,
    output o_Tx_Active,
    output o_Tx_Done,
    output o_Tx_Level
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parameterised UART transmitter (start, DATA_BITS LSB first,
// optional parity, 1 or 2 stop bits, one-cycle cleanup with o_Tx_Done).
// Input buffering: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
// without it a single holding register buffers one byte.
// All outputs are registered; o_Tx_Ready is low throughout reset.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic            i_Clock,
  input logic            i_Rst_L,
  uart_tx_param_if.slave tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 32'sd1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 32'sd1);
  localparam logic             STOP_LAST  = 1'(STOP_BITS - 32'sd1);
  localparam logic             PARITY_EN  = (PARITY_MODE != 32'sd0);
  localparam logic             PARITY_ODD = (PARITY_MODE == 32'sd1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PARITY  = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_CLEANUP = 3'd5;

  // Reject parameter sets outside the supported ranges at elaboration
  if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
      (PARITY_MODE < 0) || (PARITY_MODE > 2) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (FIFO_DEPTH < 2) || (FIFO_DEPTH > 64) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
    $error("uart_tx_param: illegal parameter combination");
  end

  // Parity over the payload; odd mode inverts the even result
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    frame_parity = (^data) ^ odd;
  endfunction

  // Sequencer state
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  // Storage state shared by both buffering options
  logic [6:0]           level_q, level_d;
  logic                 ready_q, ready_d;
  logic                 push_s;
  logic                 pop_s;
  logic                 avail_s;
  logic                 bit_end_s;
  logic [DATA_BITS-1:0] head_s;

  assign push_s    = tx.i_Tx_DV & ready_q;
  assign avail_s   = (level_q != 7'd0);
  assign bit_end_s = (cnt_q == CNT_LAST);

`ifdef UART_TX_FIFO_EN
  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [6:0] CAP   = 7'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;

  assign head_s = mem_q[rd_ptr_q];

  // FIFO next state: write at wr_ptr, read at rd_ptr, level tracks both
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = tx.i_Tx_Byte;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    level_d = level_q + {6'b000000, push_s} - {6'b000000, pop_s};
    ready_d = (level_d != CAP);
  end

  // FIFO registers; reset discards any buffered bytes
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {DATA_BITS{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  logic [DATA_BITS-1:0] hold_q, hold_d;

  assign head_s = hold_q;

  // Holding register next state: accepts only when empty, empties on frame start
  always_comb begin
    hold_d  = hold_q;
    level_d = level_q;
    if (push_s) begin
      hold_d  = tx.i_Tx_Byte;
      level_d = 7'd1;
    end else if (pop_s) begin
      level_d = 7'd0;
    end else begin
      level_d = level_q;
    end
    ready_d = (level_d == 7'd0);
  end

  // Holding register payload
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hold_q <= {DATA_BITS{1'b0}};
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  // Frame sequencer; serial/active/done are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    pop_s      = 1'b0;
    case (state_q)
      S_IDLE, S_CLEANUP: begin
        cnt_d      = {CNT_W{1'b0}};
        bit_idx_d  = {BIT_W{1'b0}};
        stop_idx_d = 1'b0;
        if (avail_s) begin
          pop_s    = 1'b1;
          state_d  = S_START;
          shift_d  = head_s;
          parity_d = frame_parity(head_s, PARITY_ODD);
          serial_d = 1'b0;
          active_d = 1'b1;
        end else begin
          state_d  = S_IDLE;
          serial_d = 1'b1;
          active_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_DATA;
          serial_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = {CNT_W{1'b0}};
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = {BIT_W{1'b0}};
            if (PARITY_EN) begin
              state_d  = S_PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1'b1);
            serial_d  = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          cnt_d    = {CNT_W{1'b0}};
          state_d  = S_STOP;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = {CNT_W{1'b0}};
          if (stop_idx_q == STOP_LAST) begin
            stop_idx_d = 1'b0;
            state_d    = S_CLEANUP;
            done_d     = 1'b1;
            active_d   = 1'b0;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = {CNT_W{1'b0}};
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // Sequencer, output and storage-status registers; reset aborts any frame with line high
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      bit_idx_q  <= {BIT_W{1'b0}};
      stop_idx_q <= 1'b0;
      shift_q    <= {DATA_BITS{1'b0}};
      parity_q   <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      level_q    <= 7'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
    end
  end

  assign tx.o_Tx_Ready  = ready_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Tx_Level  = level_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances with different frame formats share
// one clock/reset; only the selected instance receives writes and is checked.
// The reference model is a list of accepted bytes with their computed frame
// start cycles; every cycle the expected line, status and level are derived
// from that list by plain arithmetic.
module tb_uart_tx_param;

  localparam int NDUT = 4;
  localparam int P_CLKS [NDUT] = '{4, 4, 3, 4};
  localparam int P_DB   [NDUT] = '{8, 8, 8, 5};
  localparam int P_PAR  [NDUT] = '{0, 2, 1, 0};
  localparam int P_STOP [NDUT] = '{1, 2, 1, 1};
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [8:0] data;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic [8:0] din;
  int         sel;
  int         cyc;
  bit         ready_ok;
  int         errors;
  int         checks;
  frame_t     fq[$];

  logic [3:0] ser_v, act_v, done_v, rdy_v;
  logic [6:0] lvl_v [NDUT];

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) u0 ();
  uart_tx_param_if #(.DATA_BITS(8)) u1 ();
  uart_tx_param_if #(.DATA_BITS(8)) u2 ();
  uart_tx_param_if #(.DATA_BITS(5)) u3 ();

  assign u0.i_Tx_DV = dv && (sel == 0);
  assign u1.i_Tx_DV = dv && (sel == 1);
  assign u2.i_Tx_DV = dv && (sel == 2);
  assign u3.i_Tx_DV = dv && (sel == 3);
  assign u0.i_Tx_Byte = din[7:0];
  assign u1.i_Tx_Byte = din[7:0];
  assign u2.i_Tx_Byte = din[7:0];
  assign u3.i_Tx_Byte = din[4:0];

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut0 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(u0));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut1 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(u1));
  uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut2 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(u2));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut3 (.i_Clock(clk), .i_Rst_L(rst_n), .tx(u3));

  assign ser_v  = {u3.o_Tx_Serial, u2.o_Tx_Serial, u1.o_Tx_Serial, u0.o_Tx_Serial};
  assign act_v  = {u3.o_Tx_Active, u2.o_Tx_Active, u1.o_Tx_Active, u0.o_Tx_Active};
  assign done_v = {u3.o_Tx_Done,   u2.o_Tx_Done,   u1.o_Tx_Done,   u0.o_Tx_Done};
  assign rdy_v  = {u3.o_Tx_Ready,  u2.o_Tx_Ready,  u1.o_Tx_Ready,  u0.o_Tx_Ready};
  assign lvl_v[0] = u0.o_Tx_Level;
  assign lvl_v[1] = u1.o_Tx_Level;
  assign lvl_v[2] = u2.o_Tx_Level;
  assign lvl_v[3] = u3.o_Tx_Level;

  // Whole frame length in clocks for instance s
  function automatic int frame_len(input int s);
    return P_CLKS[s] * (1 + P_DB[s] + ((P_PAR[s] != 0) ? 1 : 0) + P_STOP[s]);
  endfunction

  // Line level in bit period k of a frame carrying data on instance s
  function automatic logic frame_bit(input logic [8:0] data, input int k, input int s);
    int ones;
    ones = 0;
    if (k == 0) return 1'b0;
    if (k <= P_DB[s]) return data[k-1];
    if ((P_PAR[s] != 0) && (k == P_DB[s] + 1)) begin
      for (int i = 0; i < P_DB[s]; i++) ones += int'(data[i]);
      if (P_PAR[s] == 2) return ((ones % 2) == 1);
      return ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%0d expected=%0d", tag, sel, cyc, obs, exp);
    end
  endtask

  // Compare the selected instance against the model for the current cycle
  task automatic check_cycle(output int occ);
    logic e_ser, e_act, e_done, e_rdy;
    int   len;
    e_ser  = 1'b1;
    e_act  = 1'b0;
    e_done = 1'b0;
    occ    = 0;
    len    = frame_len(sel);
    foreach (fq[i]) begin
      if ((cyc >= fq[i].start) && (cyc < fq[i].start + len)) begin
        e_act = 1'b1;
        e_ser = frame_bit(fq[i].data, (cyc - fq[i].start) / P_CLKS[sel], sel);
      end
      if (cyc == fq[i].start + len) e_done = 1'b1;
      if (fq[i].start > cyc) occ++;
    end
    e_rdy = ready_ok && (occ < CAP);
    chk("serial", 8'(ser_v[sel]),  8'(e_ser));
    chk("active", 8'(act_v[sel]),  8'(e_act));
    chk("done",   8'(done_v[sel]), 8'(e_done));
    chk("ready",  8'(rdy_v[sel]),  8'(e_rdy));
    chk("level",  8'(lvl_v[sel]),  8'(occ));
  endtask

  // One clock: check, drive a possible write, record it if it will be accepted
  task automatic step(input bit wr, input logic [8:0] d);
    int occ;
    int s;
    @(negedge clk);
    check_cycle(occ);
    dv  = wr;
    din = d;
    if (wr && ready_ok && (occ < CAP)) begin
      s = cyc + 2;
      if ((fq.size() > 0) && (fq[$].start + frame_len(sel) + 1 > s)) s = fq[$].start + frame_len(sel) + 1;
      fq.push_back('{data: d, start: s});
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'($urandom));
  endtask

  task automatic drain();
    step(1'b0, 9'($urandom));
    while ((fq.size() > 0) && (cyc <= fq[$].start + frame_len(sel) + 1)) step(1'b0, 9'($urandom));
  endtask

  task automatic select(input int s);
    drain();
    fq.delete();
    sel = s;
  endtask

  // Asynchronous reset mid-cycle; outputs must be idle before the next edge
  task automatic do_reset();
    int occ;
    @(negedge clk);
    dv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    fq.delete();
    ready_ok = 1'b0;
    chk("rst_serial", 8'(ser_v[sel]),  8'd1);
    chk("rst_active", 8'(act_v[sel]),  8'd0);
    chk("rst_done",   8'(done_v[sel]), 8'd0);
    chk("rst_level",  8'(lvl_v[sel]),  8'd0);
    chk("rst_ready",  8'(rdy_v[sel]),  8'd0);
    repeat (2) begin
      @(negedge clk);
      check_cycle(occ);
    end
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    ready_ok = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    errors   = 0;
    checks   = 0;
    cyc      = 0;
    sel      = 0;
    ready_ok = 1'b0;
    dv       = 1'b0;
    din      = 9'd0;
    rst_n    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_cycle(occ);
    end
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    ready_ok = 1'b1;

    // Basic frame 0xA5, 4 clocks per bit, no parity
    step(1'b1, 9'h0A5);
    drain();

    // Write during frame, then a third write while storage may be full
    step(1'b1, 9'h03C);
    idle(5);
    step(1'b1, 9'h03D);
    idle(3);
    step(1'b1, 9'h099);
    drain();

    // Five writes on consecutive cycles
    step(1'b1, 9'h011);
    step(1'b1, 9'h022);
    step(1'b1, 9'h033);
    step(1'b1, 9'h044);
    step(1'b1, 9'h055);
    drain();

    // Reset in the middle of the data bits of 0xF0, then a clean 0x0F frame
    step(1'b1, 9'h0F0);
    idle(14);
    do_reset();
    step(1'b1, 9'h00F);
    drain();

    // Even parity with two stop bits, odd parity, five data bits
    select(1);
    step(1'b1, 9'h007);
    drain();
    select(2);
    step(1'b1, 9'h007);
    drain();
    select(3);
    step(1'b1, 9'h0FF);
    drain();

    // Random traffic on every instance
    for (int s = 0; s < NDUT; s++) begin
      select(s);
      for (int k = 0; k < 150; k++) step($urandom_range(0, 5) == 0, 9'($urandom));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning input FIFO entries (power of two, 2..64), used only with UART_TX_FIFO_EN.
REQ-006 SHALL have port i_Clock, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port i_Rst_L, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port i_Tx_DV, input, 1, write strobe for i_Tx_Byte.
REQ-009 SHALL have port i_Tx_Byte, input, DATA_BITS, frame payload.
REQ-010 SHALL have port o_Tx_Ready, output, 1, high when a write is accepted this cycle.
REQ-011 SHALL have port o_Tx_Serial, output, 1, serial line, idle high.
REQ-012 SHALL have port o_Tx_Active, output, 1, frame in progress.
REQ-013 SHALL have port o_Tx_Done, output, 1, one-cycle end-of-frame pulse.
REQ-014 SHALL have port o_Tx_Level, output, 7, entries held (FIFO count, or 0/1 holding register).

Function
REQ-015 SHALL accept a write only on a cycle with i_Tx_DV and o_Tx_Ready both high; i_Tx_DV with o_Tx_Ready low SHALL be ignored and the byte dropped.
REQ-016 SHALL use states IDLE, START, DATA, PARITY, STOP, CLEANUP; PARITY visited only when PARITY_MODE is nonzero.
REQ-017 IDLE -> START on the cycle after data is available; o_Tx_Serial low for exactly CLKS_PER_BIT cycles in START.
REQ-018 DATA SHALL send DATA_BITS bits LSB first, each held exactly CLKS_PER_BIT cycles; bit index wraps to 0 on leaving DATA.
REQ-019 PARITY bit = XOR of data bits (even), inverted XOR (odd), held CLKS_PER_BIT cycles.
REQ-020 STOP SHALL drive high for STOP_BITS x CLKS_PER_BIT cycles, then CLKS -> CLEANUP for one cycle, then IDLE.
REQ-021 o_Tx_Done SHALL be high exactly during the CLEANUP cycle; o_Tx_Active high from first START cycle through last STOP cycle.
REQ-022 If data is available in CLEANUP, SHALL enter START on the next cycle (back-to-back frames, one idle-high cycle between stop and start).
REQ-023 Payload SHALL be captured into a shift register on START entry; i_Tx_Byte changes afterward SHALL not affect the frame.
REQ-024 Bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and reset to 0 on every bit boundary.
REQ-025 Simultaneous accept and dequeue in one cycle SHALL leave o_Tx_Level unchanged.

Reset
REQ-026 On i_Rst_L low, asynchronously: state IDLE, o_Tx_Serial 1, o_Tx_Active 0, o_Tx_Done 0, o_Tx_Level 0, counters and pointers 0, buffered data discarded.
REQ-027 Reset mid-frame SHALL abort the frame immediately with line high; no o_Tx_Done pulse for the aborted frame.
REQ-028 o_Tx_Ready SHALL be 0 while i_Rst_L low and SHALL reflect storage state from the first clock after release.

Configuration
REQ-029 With macro UART_TX_FIFO_EN defined, input storage SHALL be a FIFO_DEPTH-entry FIFO; o_Tx_Ready = not full, writes accepted during a frame, full-plus-dequeue cycle still reports not ready.
REQ-030 Without UART_TX_FIFO_EN, storage SHALL be a single holding register; o_Tx_Ready high only when register empty; FIFO_DEPTH ignored.

Verification
REQ-031 CLKS_PER_BIT=4, DATA_BITS=8, PARITY_MODE=0, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each 4 cycles; o_Tx_Done single pulse 1 cycle after stop ends.
REQ-032 PARITY_MODE=2, write 0x07 -> parity bit 1; PARITY_MODE=1, write 0x07 -> parity bit 0; STOP_BITS=2 -> stop high 8 cycles.
REQ-033 FIFO_EN, FIFO_DEPTH=4, write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> first four sent back-to-back in order, 0x55 dropped only if ready was low, o_Tx_Level peaks 4.
REQ-034 No FIFO_EN, write 0x3C then 0x3D during frame -> 0x3D accepted into holding register, sent immediately after 0x3C; a third write while register full ignored.
REQ-035 Assert i_Rst_L low mid-DATA of 0xF0 -> o_Tx_Serial 1 same cycle, no o_Tx_Done, o_Tx_Level 0; next write 0x0F transmits a clean frame.
REQ-036 DATA_BITS=5, write 0x1F (upper bits ignored) -> frame of 5 ones between start and stop, 7 bit periods total.
